theta_apply: RTL and testbench
==============================

THETA_APPLY -- requirements
Module: theta_apply

Interface
REQ-001 SHALL have parameter SLICES, default 64, number of z-slices (parity and slice memory depth).
REQ-002 SHALL have parameter LANES, default 25, bits per slice (5x5, bit index i = x + 5*y).
REQ-003 SHALL have ports: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset; the design SHALL use one clock and synchronous, active-high reset.
REQ-004 SHALL have ports: start  input  1  begin one pass; ready  output  1  idle, accepting start; done  output  1  one-cycle pass-complete pulse.
REQ-005 SHALL have ports: par_rd  output  1  parity memory read strobe; par_addr  output  6  parity address; par_data  input  5  column parity C[x], bit x, valid the cycle after par_rd.
REQ-006 SHALL have ports: in_rd  output  1  slice memory read strobe; in_addr  output  6  slice address; in_data  input  25  slice, valid the cycle after in_rd.
REQ-007 SHALL have ports: out_wr  output  1  result write strobe; out_addr  output  6  result address; out_data  output  25  theta-applied slice.

Function
REQ-008 SHALL implement a Moore FSM: IDLE, RD_PREV, CAP_PREV, RD_CUR, CAP_CUR, WRITE, DONE.
REQ-009 IDLE: ready=1; start=1 -> RD_PREV, z counter cleared to 0; else stay.
REQ-010 RD_PREV: par_rd=1, par_addr=SLICES-1 (wrap source for z=0); -> CAP_PREV.
REQ-011 CAP_PREV: prev_reg <= par_data; -> RD_CUR.
REQ-012 RD_CUR: par_rd=1, in_rd=1, par_addr=in_addr=z; -> CAP_CUR.
REQ-013 CAP_CUR: cur_reg <= par_data, slice_reg <= in_data; -> WRITE.
REQ-014 WRITE: out_wr=1, out_addr=z, out_data per REQ-015; prev_reg <= cur_reg; z=SLICES-1 -> DONE, else z <= z+1 and -> RD_CUR.
REQ-015 out_data[x+5y] SHALL equal slice_reg[x+5y] ^ cur_reg[(x+4) mod 5] ^ prev_reg[(x+1) mod 5], for all x,y in 0..4.
REQ-016 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-017 All strobes (par_rd, in_rd, out_wr, done) SHALL be 0 in every state not listed for them; addresses SHALL be 0 when their strobe is 0.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 Pass length SHALL be exactly 2 + 3*SLICES + 1 = 195 cycles from leaving IDLE to end of DONE; first out_wr in the 5th cycle after start is sampled.
REQ-020 Each address z SHALL be written exactly once per pass, in ascending order 0..63.
REQ-021 z counter SHALL be 6 bits and SHALL NOT wrap within a pass (terminal detect at 63).

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE, z=0, prev_reg/cur_reg/slice_reg=0, regardless of state.
REQ-023 After reset: ready=1, done=0, par_rd=in_rd=out_wr=0, all addresses 0, out_data 0.
REQ-024 Reset mid-pass SHALL abort with no further out_wr; a new start SHALL begin a full pass from RD_PREV.

Structure
REQ-025 Shared package SHALL hold SLICES, LANES, column count 5, address width 6, and state encoding constants.
REQ-026 Control FSM and datapath SHALL be split into controller and datapath modules, with out_data computed by one combinational sub-module theta_slice_xor (inputs slice, cur, prev; output 25 bits).

Verification
REQ-027 All parity memory 0, random slices -> every out_data equals in_data at same z; done after 195 cycles.
REQ-028 Only C[0] at z=5 set -> out[5] flips bits 1,6,11,16,21; out[6] flips bits 4,9,14,19,24; all else equal input.
REQ-029 Wrap: only C[2] at z=63 set -> out[0] flips bits 1,6,11,16,21; out[63] flips bits 3,8,13,18,23.
REQ-030 start pulsed during WRITE of z=10 -> no effect; exactly 64 out_wr, single done pulse.
REQ-031 rst at z=20 during CAP_CUR -> next cycle IDLE, ready=1, no out_wr; restart produces full correct 64-slice pass.
REQ-032 Random parity and slices vs reference theta model -> all 64 outputs match; out_addr sequence 0..63.

Source files
------------

// File: rtl/theta_apply_pkg.sv
// Shared constants and FSM state type for the theta_apply slice engine.
// No ports: holds default geometry (slices, lanes), column count,
// address width and the controller state enumeration.
package theta_apply_pkg;
   localparam int unsigned SLICES_DEF = 64;
   localparam int unsigned LANES_DEF  = 25;
   localparam int unsigned COLS       = 5;
   localparam int unsigned AW         = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_PREV,
      S_CAP_PREV,
      S_RD_CUR,
      S_CAP_CUR,
      S_WRITE,
      S_DONE
   } state_e;
endpackage

// File: rtl/theta_apply_if.sv
// Bus bundle for theta_apply: control handshake, parity-memory read port,
// slice-memory read port and result write port.
// slave  : the engine side (drives strobes, addresses, results)
// master : the environment side (drives start and memory read data)
interface theta_apply_if;
   import theta_apply_pkg::*;

   logic                      start;
   logic                      ready;
   logic                      done;
   logic                      par_rd;
   logic [AW-1:0]             par_addr;
   logic [COLS-1:0]           par_data;
   logic                      in_rd;
   logic [AW-1:0]             in_addr;
   logic [LANES_DEF-1:0]      in_data;
   logic                      out_wr;
   logic [AW-1:0]             out_addr;
   logic [LANES_DEF-1:0]      out_data;

   modport slave (
      input  start, par_data, in_data,
      output ready, done, par_rd, par_addr, in_rd, in_addr,
             out_wr, out_addr, out_data
   );

   modport master (
      output start, par_data, in_data,
      input  ready, done, par_rd, par_addr, in_rd, in_addr,
             out_wr, out_addr, out_data
   );
endinterface

// File: rtl/theta_apply_ctrl.sv
// Control FSM and z counter for theta_apply.
// Ports: clk_i/rst_i, start_i; ready_o/done_o handshake; memory strobes
// and addresses; cap_prev_o/cap_cur_o/write_o steer the datapath registers.
module theta_apply_ctrl
   import theta_apply_pkg::*;
#(
   parameter int unsigned SLICES = SLICES_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   output logic          ready_o,
   output logic          done_o,
   output logic          par_rd_o,
   output logic [AW-1:0] par_addr_o,
   output logic          in_rd_o,
   output logic [AW-1:0] in_addr_o,
   output logic          out_wr_o,
   output logic [AW-1:0] out_addr_o,
   output logic          cap_prev_o,
   output logic          cap_cur_o,
   output logic          write_o
);
   localparam logic [AW-1:0] LAST = AW'(SLICES - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] z_q, z_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      z_d        = z_q;
      ready_o    = 1'b0;
      done_o     = 1'b0;
      par_rd_o   = 1'b0;
      par_addr_o = '0;
      in_rd_o    = 1'b0;
      in_addr_o  = '0;
      out_wr_o   = 1'b0;
      out_addr_o = '0;
      cap_prev_o = 1'b0;
      cap_cur_o  = 1'b0;
      write_o    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ready_o = 1'b1;
            if (start_i) begin
               state_d = S_RD_PREV;
               z_d     = '0;
            end
         end
         S_RD_PREV: begin
            // parity of the last slice is the wrap-around neighbour of z=0
            par_rd_o   = 1'b1;
            par_addr_o = LAST;
            state_d    = S_CAP_PREV;
         end
         S_CAP_PREV: begin
            cap_prev_o = 1'b1;
            state_d    = S_RD_CUR;
         end
         S_RD_CUR: begin
            par_rd_o   = 1'b1;
            par_addr_o = z_q;
            in_rd_o    = 1'b1;
            in_addr_o  = z_q;
            state_d    = S_CAP_CUR;
         end
         S_CAP_CUR: begin
            cap_cur_o = 1'b1;
            state_d   = S_WRITE;
         end
         S_WRITE: begin
            out_wr_o   = 1'b1;
            out_addr_o = z_q;
            write_o    = 1'b1;
            if (z_q == LAST) begin
               state_d = S_DONE;
            end else begin
               z_d     = z_q + 1'b1;
               state_d = S_RD_CUR;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: rtl/theta_apply_dp.sv
// Datapath for theta_apply: previous/current parity and slice registers
// plus the combinational theta step.
// Ports: clk_i/rst_i; cap_prev_i/cap_cur_i/write_i from the controller;
// par_data_i/in_data_i from memories; out_data_o result (zero when idle).
module theta_apply_dp
   import theta_apply_pkg::*;
#(
   parameter int unsigned LANES = LANES_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cap_prev_i,
   input  logic                 cap_cur_i,
   input  logic                 write_i,
   input  logic [COLS-1:0]      par_data_i,
   input  logic [LANES-1:0]     in_data_i,
   output logic [LANES_DEF-1:0] out_data_o
);
   logic [COLS-1:0]      prev_q, prev_d;
   logic [COLS-1:0]      cur_q, cur_d;
   logic [LANES-1:0]     slice_q, slice_d;
   logic [LANES_DEF-1:0] xor_out;

   always_comb begin
      prev_d  = prev_q;
      cur_d   = cur_q;
      slice_d = slice_q;
      if (cap_prev_i) prev_d = par_data_i;
      if (cap_cur_i) begin
         cur_d   = par_data_i;
         slice_d = in_data_i;
      end
      // the current parity becomes the z-1 neighbour for the next slice
      if (write_i) prev_d = cur_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q  <= '0;
         cur_q   <= '0;
         slice_q <= '0;
      end else begin
         prev_q  <= prev_d;
         cur_q   <= cur_d;
         slice_q <= slice_d;
      end
   end

   theta_slice_xor u_xor (
      .slice_i (slice_q),
      .cur_i   (cur_q),
      .prev_i  (prev_q),
      .out_o   (xor_out)
   );

   assign out_data_o = write_i ? xor_out : '0;
endmodule

// File: rtl/theta_slice_xor.sv
// Combinational theta step for one 5x5 slice.
// slice_i : 25-bit slice, bit index x + 5*y
// cur_i   : column parity of this slice, bit x
// prev_i  : column parity of the previous slice (z-1), bit x
// out_o   : slice with D[x] = cur[x-1] ^ prev[x+1] folded into every row
module theta_slice_xor
   import theta_apply_pkg::*;
(
   input  logic [LANES_DEF-1:0] slice_i,
   input  logic [COLS-1:0]      cur_i,
   input  logic [COLS-1:0]      prev_i,
   output logic [LANES_DEF-1:0] out_o
);
   always_comb begin
      out_o = slice_i;
      for (int unsigned x = 0; x < COLS; x++) begin
         for (int unsigned y = 0; y < COLS; y++) begin
            out_o[x + COLS*y] = slice_i[x + COLS*y]
                              ^ cur_i[(x + COLS - 1) % COLS]
                              ^ prev_i[(x + 1) % COLS];
         end
      end
   end
endmodule

// File: rtl/theta_apply.sv
// theta_apply top: streams 64 slices through the theta column-parity step,
// reading parity C[x] and slice data from external memories and writing
// each result slice once, in ascending z order.
// Ports: clk, rst (sync, active high); bus (theta_apply_if.slave) carrying
// start/ready/done, parity read port, slice read port and result write port.
module theta_apply
   import theta_apply_pkg::*;
#(
   parameter int unsigned SLICES = SLICES_DEF,
   parameter int unsigned LANES  = LANES_DEF
) (
   input  logic           clk,
   input  logic           rst,
   theta_apply_if.slave   bus
);
   logic cap_prev, cap_cur, write_en;

   theta_apply_ctrl #(.SLICES(SLICES)) u_ctrl (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (bus.start),
      .ready_o    (bus.ready),
      .done_o     (bus.done),
      .par_rd_o   (bus.par_rd),
      .par_addr_o (bus.par_addr),
      .in_rd_o    (bus.in_rd),
      .in_addr_o  (bus.in_addr),
      .out_wr_o   (bus.out_wr),
      .out_addr_o (bus.out_addr),
      .cap_prev_o (cap_prev),
      .cap_cur_o  (cap_cur),
      .write_o    (write_en)
   );

   theta_apply_dp #(.LANES(LANES)) u_dp (
      .clk_i      (clk),
      .rst_i      (rst),
      .cap_prev_i (cap_prev),
      .cap_cur_i  (cap_cur),
      .write_i    (write_en),
      .par_data_i (bus.par_data),
      .in_data_i  (bus.in_data),
      .out_data_o (bus.out_data)
   );
endmodule

// File: tb/tb_theta_apply.sv
// Scoreboard bench for theta_apply: memories modelled in the bench,
// expected writes queued per pass, a negedge monitor pops and compares.
module tb_theta_apply;
   import theta_apply_pkg::*;

   typedef struct packed {
      logic [5:0]  a;
      logic [24:0] d;
   } exp_t;

   localparam logic [24:0] M_X1 = 25'h0210842; // bits 1,6,11,16,21
   localparam logic [24:0] M_X3 = 25'h0842108; // bits 3,8,13,18,23
   localparam logic [24:0] M_X4 = 25'h1084210; // bits 4,9,14,19,24

   logic clk = 1'b0;
   logic rst = 1'b1;
   theta_apply_if bus();

   logic [4:0]  par_mem [64];
   logic [24:0] slc_mem [64];
   logic [24:0] flip    [64];
   exp_t        sb[$];
   exp_t        mon_e;
   int          nchk = 0;
   int          nerr = 0;

   always #5 clk = ~clk;

   theta_apply #(.SLICES(64), .LANES(25)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // memories: read data valid the cycle after the strobe
   always @(posedge clk) begin
      if (rst) begin
         bus.par_data <= '0;
         bus.in_data  <= '0;
      end else begin
         if (bus.par_rd) bus.par_data <= par_mem[bus.par_addr];
         if (bus.in_rd)  bus.in_data  <= slc_mem[bus.in_addr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // reference theta: D[x] = C[z][x-1] ^ C[z-1][x+1], folded into all rows
   function automatic logic [24:0] ref_slice(input int z);
      logic [4:0]  c = par_mem[z];
      logic [4:0]  p = par_mem[(z + 63) % 64];
      logic [24:0] r = slc_mem[z];
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            r[x + 5*y] = r[x + 5*y] ^ c[(x + 4) % 5] ^ p[(x + 1) % 5];
      return r;
   endfunction

   task automatic push_model();
      for (int z = 0; z < 64; z++) sb.push_back('{a: 6'(z), d: ref_slice(z)});
   endtask

   task automatic push_flip();
      for (int z = 0; z < 64; z++) sb.push_back('{a: 6'(z), d: slc_mem[z] ^ flip[z]});
   endtask

   task automatic clear_mem(input bit rnd_slice, input bit rnd_par);
      for (int z = 0; z < 64; z++) begin
         slc_mem[z] = rnd_slice ? 25'($urandom) : '0;
         par_mem[z] = rnd_par ? 5'($urandom) : '0;
         flip[z]    = '0;
      end
   endtask

   // monitor: compares every write against the scoreboard head
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_wr) begin
            if (sb.size() == 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_wr actual addr=%0d expected no write", bus.out_addr);
            end else begin
               mon_e = sb.pop_front();
               chk("wr_addr", 32'(bus.out_addr), 32'(mon_e.a));
               chk("wr_data", 32'(bus.out_data), 32'(mon_e.d));
            end
         end else begin
            chk("out_addr_idle", 32'(bus.out_addr), 32'd0);
         end
         if (!bus.par_rd) chk("par_addr_idle", 32'(bus.par_addr), 32'd0);
         if (!bus.in_rd)  chk("in_addr_idle", 32'(bus.in_addr), 32'd0);
      end
   end

   // start_z >= 0: pulse start during WRITE of that z
   // rst_z  >= 0: assert rst during CAP_CUR of that z and abandon the pass
   task automatic run_pass(input int start_z, input int rst_z);
      int cyc = 0, first_wr = 0, nwr = 0;
      bit got_done = 1'b0, armed = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         bus.start = 1'b0;
         if (cyc == 1) chk("ready_busy", 32'(bus.ready), 32'd0);
         if (armed) begin
            rst = 1'b1;
            @(negedge clk);
            chk("rst_ready", 32'(bus.ready), 32'd1);
            chk("rst_out_wr", 32'(bus.out_wr), 32'd0);
            chk("rst_par_rd", 32'(bus.par_rd), 32'd0);
            rst = 1'b0;
            sb.delete();
            repeat (6) @(negedge clk);
            chk("rst_idle_ready", 32'(bus.ready), 32'd1);
            return;
         end
         if (bus.out_wr) begin
            nwr++;
            if (first_wr == 0) first_wr = cyc;
            if (start_z >= 0 && int'(bus.out_addr) == start_z) bus.start = 1'b1;
         end
         if (rst_z >= 0 && bus.in_rd && int'(bus.in_addr) == rst_z) armed = 1'b1;
         if (bus.done) begin
            got_done = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(got_done), 32'd1);
      chk("pass_cycles", 32'(cyc), 32'd195);
      chk("first_wr_cycle", 32'(first_wr), 32'd5);
      chk("wr_count", 32'(nwr), 32'd64);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      @(negedge clk);
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("ready_after", 32'(bus.ready), 32'd1);
      if (!got_done) sb.delete();
   endtask

   initial begin
      bus.start = 1'b0;
      clear_mem(1'b0, 1'b0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_strobes", 32'({bus.par_rd, bus.in_rd, bus.out_wr}), 32'd0);
      chk("rst_addrs", 32'({bus.par_addr, bus.in_addr, bus.out_addr}), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);

      // zero parity: output equals input slice
      clear_mem(1'b1, 1'b0);
      push_flip();
      run_pass(-1, -1);

      // single C[0] at z=5
      clear_mem(1'b1, 1'b0);
      par_mem[5] = 5'b00001;
      flip[5] = M_X1;
      flip[6] = M_X4;
      push_flip();
      run_pass(-1, -1);

      // wrap: single C[2] at z=63
      clear_mem(1'b1, 1'b0);
      par_mem[63] = 5'b00100;
      flip[0]  = M_X1;
      flip[63] = M_X3;
      push_flip();
      run_pass(-1, -1);

      // start pulse during WRITE of z=10 is ignored
      clear_mem(1'b1, 1'b1);
      push_model();
      run_pass(10, -1);

      // reset mid-pass, then a full restart
      clear_mem(1'b1, 1'b1);
      push_model();
      run_pass(-1, 20);
      push_model();
      run_pass(-1, -1);

      // random parity and slices
      clear_mem(1'b1, 1'b1);
      push_model();
      run_pass(-1, -1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
